// File: rtl/uart_rx.sv
// 8N1 UART receiver: LSB-first, mid-bit sampling, baud timing from CLK_FREQ/BAUD_RATE.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on data and stop bits.
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_idle
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt, err_nxt;
    logic             s1, s2, s3;
    logic             bit_val;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_S0 = CNT_W'(BAUD_DIV - 3);
    localparam logic [CNT_W-1:0] CNT_S1 = CNT_W'(BAUD_DIV - 2);

    logic [1:0] samp, samp_nxt;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // The third vote is the live s2 at CNT_LAST, so latency matches the single-sample build.
    assign bit_val = maj3(samp[1], samp[0], s2);

    always_comb begin
        samp_nxt = samp;
        if (state == DATA || state == STOP) begin
            if (cnt == CNT_S0) samp_nxt[0] = s2;
            if (cnt == CNT_S1) samp_nxt[1] = s2;
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) samp <= 2'b00;
        else     samp <= samp_nxt;
    end
`else
    assign bit_val = s2;
`endif

    assign rx_idle = (state == IDLE);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        data_nxt    = rx_data;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                // s3 high with s2 low is a true 1->0 transition; a line stuck low never qualifies.
                if (s3 && !s2) state_nxt = START;
            end
            START: begin
                bit_idx_nxt = '0;
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    state_nxt = s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {bit_val, shift_reg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = '0;
                        state_nxt   = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (bit_val) begin
                        valid_nxt = 1'b1;
                        data_nxt  = shift_reg;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            s1           <= rs232_rx;
            s2           <= s1;
            s3           <= s2;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            shift_reg    <= shift_nxt;
            rx_data      <= data_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= err_nxt;
        end
    end

endmodule
